// File: rtl/des_round_key_stream.sv
// DES key scheduler: loads a post-PC1 key once and streams the 16 PC2 round keys
// over valid/ready, K1..K16 for encryption and K16..K1 for decryption.

module des_key_permutation2 (
    input  logic [0:55] input_wires,
    output logic [0:47] output_wires
);
    // PC2 selection; indices are zero-based positions in {C,D}
    assign output_wires = {
        input_wires[13], input_wires[16], input_wires[10], input_wires[23], input_wires[0],  input_wires[4],
        input_wires[2],  input_wires[27], input_wires[14], input_wires[5],  input_wires[20], input_wires[9],
        input_wires[22], input_wires[18], input_wires[11], input_wires[3],  input_wires[25], input_wires[7],
        input_wires[15], input_wires[6],  input_wires[26], input_wires[19], input_wires[12], input_wires[1],
        input_wires[40], input_wires[51], input_wires[30], input_wires[36], input_wires[46], input_wires[54],
        input_wires[29], input_wires[39], input_wires[50], input_wires[44], input_wires[32], input_wires[47],
        input_wires[43], input_wires[48], input_wires[38], input_wires[55], input_wires[33], input_wires[52],
        input_wires[45], input_wires[41], input_wires[49], input_wires[35], input_wires[28], input_wires[31]
    };
endmodule

module des_round_key_stream (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [0:55] input_key,
    input  logic        is_encrypt,
    output logic        key_valid,
    input  logic        key_ready,
    output logic [0:47] round_key,
    output logic [3:0]  round_index,
    output logic        busy,
    output logic        done
);
    localparam int unsigned HALF_W = 28;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [0:HALF_W-1]   c_reg, d_reg, c_next, d_next;
    logic [CNT_W-1:0]    cnt, cnt_next, cnt_inc;
    logic                enc, enc_next, done_next;
    logic                xfer, by_two;
    logic [0:47]         pc2_out;

    function automatic logic [0:HALF_W-1] rotl(input logic [0:HALF_W-1] x, input logic two);
        return two ? {x[2:HALF_W-1], x[0:1]} : {x[1:HALF_W-1], x[0]};
    endfunction

    function automatic logic [0:HALF_W-1] rotr(input logic [0:HALF_W-1] x, input logic two);
        return two ? {x[HALF_W-2:HALF_W-1], x[0:HALF_W-3]} : {x[HALF_W-1], x[0:HALF_W-2]};
    endfunction

    assign key_valid   = (state == STREAM);
    assign busy        = (state == STREAM);
    assign round_index = cnt;
    assign xfer        = key_valid && key_ready;
    assign cnt_inc     = cnt + CNT_W'(1);
    // Single-bit shifts fall where the DES schedule has them, in both directions
    assign by_two      = !((cnt_inc == CNT_W'(1)) || (cnt_inc == CNT_W'(8)) || (cnt_inc == CNT_W'(15)));

    des_key_permutation2 u_pc2 (
        .input_wires  ({c_reg, d_reg}),
        .output_wires (pc2_out)
    );

    assign round_key = key_valid ? pc2_out : '0;

    // Next-state and register update logic
    always_comb begin
        state_next = state;
        c_next     = c_reg;
        d_next     = d_reg;
        cnt_next   = cnt;
        enc_next   = enc;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = STREAM;
                    cnt_next   = '0;
                    enc_next   = is_encrypt;
                    if (is_encrypt) begin
                        c_next = rotl(input_key[0:27], 1'b0);
                        d_next = rotl(input_key[28:55], 1'b0);
                    end else begin
                        c_next = input_key[0:27];
                        d_next = input_key[28:55];
                    end
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (cnt == CNT_W'(15)) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        cnt_next = cnt_inc;
                        if (enc) begin
                            c_next = rotl(c_reg, by_two);
                            d_next = rotl(d_reg, by_two);
                        end else begin
                            c_next = rotr(c_reg, by_two);
                            d_next = rotr(d_reg, by_two);
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            c_reg <= '0;
            d_reg <= '0;
            cnt   <= '0;
            enc   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            c_reg <= c_next;
            d_reg <= d_next;
            cnt   <= cnt_next;
            enc   <= enc_next;
            done  <= done_next;
        end
    end
endmodule

// File: tb/tb_des_round_key_stream.sv
// Scoreboard bench for des_round_key_stream: directed key vectors plus randomized
// schedules checked against a cumulative-shift DES key schedule model.

module tb_des_round_key_stream;
    typedef struct packed {
        logic [47:0] key;
        logic [3:0]  idx;
    } exp_t;

    localparam logic [55:0] K_HAND  = 56'hF0CCAAF556678F;
    localparam logic [55:0] K_OTHER = 56'h0123456789ABCD;
    localparam int PC2_TAB [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,
                                    23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                                    41,52,31,37,47,55,30,40,51,45,33,48,
                                    44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int SHIFT_TOT [16] = '{1,2,4,6,8,10,12,14,15,17,19,21,23,25,27,28};

    logic        clk;
    logic        rst;
    logic        start;
    logic [0:55] input_key;
    logic        is_encrypt;
    logic        key_valid;
    logic        key_ready;
    logic [0:47] round_key;
    logic [3:0]  round_index;
    logic        busy;
    logic        done;

    int   n_vec;
    int   n_bad;
    bit   stall_mode;
    exp_t sbq[$];

    des_round_key_stream dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .input_key   (input_key),
        .is_encrypt  (is_encrypt),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .round_key   (round_key),
        .round_index (round_index),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [63:0] got, input logic [63:0] req);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at %0t", name, got, req, $time);
        end
    endtask

    // Round key r (1..16) from the total left shift applied to C0/D0, then PC2
    function automatic logic [47:0] model_key(input logic [0:55] k, input int rnd);
        logic [0:55] cd;
        logic [0:47] o;
        int sh;
        sh = SHIFT_TOT[rnd-1];
        for (int i = 0; i < 28; i++) begin
            cd[i]      = k[(i + sh) % 28];
            cd[28 + i] = k[28 + ((i + sh) % 28)];
        end
        for (int j = 0; j < 48; j++) o[j] = cd[PC2_TAB[j] - 1];
        return o;
    endfunction

    function automatic logic [47:0] expected_key(input logic [55:0] k, input int rnd);
        logic [47:0] kk;
        kk = model_key(k, rnd);
        if (k == K_HAND) begin
            case (rnd)
                1:  kk = 48'h1B02EFFC7072;
                2:  kk = 48'h79AED9DBC9E5;
                15: kk = 48'hBF918D3D3F0A;
                16: kk = 48'hCB3D8B0E17F5;
                default: ;
            endcase
        end
        return kk;
    endfunction

    task automatic issue(input logic [55:0] k, input bit enc);
        exp_t e;
        input_key  = k;
        is_encrypt = enc;
        start      = 1'b1;
        for (int t = 0; t < 16; t++) begin
            e.key = expected_key(k, enc ? t + 1 : 16 - t);
            e.idx = 4'(t);
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        start      = 1'b0;
        input_key  = ~k;
        is_encrypt = ~enc;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(done == 1'b1, "done_seen", 64'(done), 64'(1));
    endtask

    task automatic wait_idx(input logic [3:0] idx, input int budget);
        int n;
        n = 0;
        while (!(key_valid && round_index == idx) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(key_valid && round_index == idx, "reach_idx", 64'(round_index), 64'(idx));
    endtask

    task automatic chk_idle(input string tag);
        chk(key_valid == 1'b0, {tag, "_valid"}, 64'(key_valid), 64'(0));
        chk(round_key == '0, {tag, "_key"}, 64'(round_key), 64'(0));
        chk(round_index == '0, {tag, "_index"}, 64'(round_index), 64'(0));
        chk(busy == 1'b0, {tag, "_busy"}, 64'(busy), 64'(0));
        chk(done == 1'b0, {tag, "_done"}, 64'(done), 64'(0));
    endtask

    // Consumer ready: held high or randomly stalled
    initial begin
        key_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            key_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Monitor: pops expectations on transfers, checks stall stability and done timing
    initial begin
        exp_t        e;
        bit          prev_stall;
        bit          done_exp;
        logic [0:47] pk;
        logic [3:0]  pi;
        prev_stall = 1'b0;
        done_exp   = 1'b0;
        pk         = '0;
        pi         = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                done_exp   = 1'b0;
            end else begin
                if (done || done_exp) chk(done == done_exp, "done_pulse", 64'(done), 64'(done_exp));
                done_exp = 1'b0;
                if (prev_stall) begin
                    chk(key_valid == 1'b1, "stall_valid", 64'(key_valid), 64'(1));
                    chk(round_key == pk, "stall_key", 64'(round_key), 64'(pk));
                    chk(round_index == pi, "stall_index", 64'(round_index), 64'(pi));
                end
                prev_stall = key_valid && !key_ready;
                pk = round_key;
                pi = round_index;
                if (key_valid && key_ready) begin
                    chk(sbq.size() != 0, "unexpected_key", 64'(round_key), 64'(0));
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        chk(round_key == e.key, "round_key", 64'(round_key), 64'(e.key));
                        chk(round_index == e.idx, "round_index", 64'(round_index), 64'(e.idx));
                        if (e.idx == 4'd15) done_exp = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        stall_mode = 1'b0;
        rst        = 1'b1;
        start      = 1'b0;
        is_encrypt = 1'b1;
        input_key  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed encrypt then decrypt, the latter started in the done cycle
        issue(K_HAND, 1'b1);
        wait_done(40);
        issue(K_HAND, 1'b0);
        wait_done(40);

        // Random ready stalls in both directions
        stall_mode = 1'b1;
        issue(K_HAND, 1'b1);
        wait_done(300);
        issue(K_HAND, 1'b0);
        wait_done(300);
        stall_mode = 1'b0;
        @(posedge clk); #1;

        // Start mid-stream is ignored; start in the done cycle is taken
        issue(K_HAND, 1'b1);
        wait_idx(4'd5, 40);
        start      = 1'b1;
        input_key  = K_OTHER;
        is_encrypt = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(40);
        issue(K_OTHER, 1'b0);
        wait_done(40);

        // Asynchronous reset mid-stream, then a clean restart
        issue(K_OTHER, 1'b1);
        wait_idx(4'd9, 40);
        #2 rst = 1'b1;
        #1 chk_idle("async_rst");
        sbq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("post_rst");
        issue(K_HAND, 1'b1);
        wait_done(40);

        // Randomized keys and directions
        for (int i = 0; i < 1000; i++) begin
            stall_mode = (i % 25 == 0);
            issue(56'({$urandom, $urandom}), 1'($urandom_range(0, 1)));
            wait_done(stall_mode ? 300 : 40);
        end
        stall_mode = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk(sbq.size() == 0, "scoreboard_drain", 64'(sbq.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
